sum_of_squares: RTL

Memory-mapped arithmetic peripheral on the 18-bit processor bus that computes X² + Y² from two signed 18-bit operands. It sits directly upstream of the square-root peripheral: software writes X and Y, waits for DONE, then writes DO into the square-root unit to obtain a vector magnitude. The block uses one shared iterative radix-4 multiplier to keep area small, trading area for a fixed multi-cycle latency.

---
 rtl/sumsq_pkg.sv | 23 ++
 rtl/sum_of_squares_if.sv | 16 +
 rtl/sumsq_mac_step.sv | 18 +
 rtl/sum_of_squares.sv | 105 ++++++++++
 4 files changed

// File: rtl/sumsq_pkg.sv
// Shared widths, FSM encoding and helpers for the sum_of_squares peripheral.
package sumsq_pkg;

  localparam int DATA_W = 18;
  localparam int ACC_W  = 36;
  localparam int DIGITS = 9;
  localparam int CNT_W  = 4;

  localparam logic [DATA_W-1:0] SAT_MAX = 18'h3FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQX  = 2'd1,
    SQY  = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Two's-complement magnitude; -131072 maps to 18'h20000, valid as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? ((~v) + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/sum_of_squares_if.sv
// Processor-bus view of the sum_of_squares peripheral.
interface sum_of_squares_if;
  import sumsq_pkg::*;

  logic              cs;
  logic              we;
  logic              addr;
  logic [DATA_W-1:0] di;
  logic [DATA_W-1:0] dout;
  logic              done;
  logic              ovf;

  modport master (output cs, we, addr, di, input dout, done, ovf);
  modport slave  (input cs, we, addr, di, output dout, done, ovf);

endinterface

// File: rtl/sumsq_mac_step.sv
// One radix-4 partial product: (mag * digit) << 2*idx, widened to the accumulator.
module sumsq_mac_step
  import sumsq_pkg::*;
(
  input  logic [DATA_W-1:0] mag,
  input  logic [1:0]        digit,
  input  logic [CNT_W-1:0]  idx,
  output logic [ACC_W-1:0]  addend
);

  logic [ACC_W-1:0] prod;

  always_comb begin
    prod   = ACC_W'(mag) * ACC_W'(digit);
    addend = prod << {idx, 1'b0};
  end

endmodule

// File: rtl/sum_of_squares.sv
// X^2 + Y^2 peripheral using one iterative radix-4 multiplier (19-cycle latency).
// Build option: define SUMSQ_SATURATE_EN to clamp DO at 18'h3FFFF on overflow.
module sum_of_squares
  import sumsq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  sum_of_squares_if.slave   bus
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] x_q, y_q, mag_q, dout_q;
  logic [ACC_W-1:0]  acc_q, addend;
  logic              ovf_q;
  logic              wr_en, start, last_digit;
  logic [1:0]        digit;

  // Writes only land while idle; busy-time writes are dropped outright.
  assign wr_en      = bus.cs & bus.we & (state == IDLE);
  assign start      = wr_en & bus.addr;
  assign last_digit = (cnt == CNT_W'(DIGITS - 1));
  assign digit      = mag_q[{cnt, 1'b0} +: 2];

  sumsq_mac_step u_mac (
    .mag    (mag_q),
    .digit  (digit),
    .idx    (cnt),
    .addend (addend)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = SQX;
      SQX:     if (last_digit) state_nxt = SQY;
      SQY:     if (last_digit) state_nxt = FIN;
      FIN:                     state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.done = (state == IDLE);
  end

  assign bus.dout = dout_q;
  assign bus.ovf  = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      mag_q  <= '0;
      acc_q  <= '0;
      cnt    <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_en && !bus.addr) x_q <= bus.di;
          if (start) begin
            y_q   <= bus.di;
            acc_q <= '0;
            cnt   <= '0;
            mag_q <= magnitude(x_q);
          end
        end
        SQX: begin
          acc_q <= acc_q + addend;
          if (last_digit) begin
            cnt   <= '0;
            mag_q <= magnitude(y_q);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SQY: begin
          acc_q <= acc_q + addend;
          if (!last_digit) cnt <= cnt + CNT_W'(1);
        end
        FIN: begin
          // Any set bit above the low 18 means the sum exceeded SAT_MAX.
          ovf_q <= |acc_q[ACC_W-1:DATA_W];
`ifdef SUMSQ_SATURATE_EN
          dout_q <= (|acc_q[ACC_W-1:DATA_W]) ? SAT_MAX : acc_q[DATA_W-1:0];
`else
          dout_q <= acc_q[DATA_W-1:0];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
